// File: rtl/edge_stream_sched.sv
// Byte-stream scheduler: UART rx -> input FIFO -> Edge filter -> output FIFO -> UART tx.
// One pixel in flight through the filter; tx drained under a busy handshake.

module esched_fifo #(
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  logic [7:0]  wdata,
  input  logic        pop,
  output logic [7:0]  rdata,
  output logic [AW:0] level,
  output logic        full,
  output logic        empty
);
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic          do_push, do_pop;

  assign full    = (level == (AW+1)'(DEPTH));
  assign empty   = (level == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem[rp];

  always_ff @(posedge clk) begin
    if (do_push) mem[wp] <= wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp    <= '0;
      rp    <= '0;
      level <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop)  rp <= rp + 1'b1;
      level <= level + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
endmodule

module edge_stream_sched #(
  parameter int DEPTH        = 4,
  parameter int EDGE_LAT     = 1,
  parameter int FRAME_PIXELS = 640
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     rx_done,
  input  logic [7:0]               rx_data,
  input  logic                     tx_busy,
  output logic                     tx_start,
  output logic [7:0]               tx_data,
  output logic                     edge_en,
  output logic [7:0]               edge_pix_in,
  input  logic [7:0]               edge_pix_out,
  output logic                     frame_done,
  output logic                     overflow,
  output logic [$clog2(DEPTH):0]   in_level
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = (FRAME_PIXELS > 1) ? $clog2(FRAME_PIXELS) : 1;
  localparam int LW = (EDGE_LAT > 1) ? $clog2(EDGE_LAT) : 1;

  typedef enum logic [1:0] {E_IDLE, E_ISSUE, E_WAIT, E_STORE} e_state_t;
  typedef enum logic [1:0] {T_IDLE, T_START, T_GUARD, T_WAIT} t_state_t;

  e_state_t e_state, e_next;
  t_state_t t_state, t_next;

  logic          rx_done_q, rx_rise;
  logic          in_pop, in_full, in_empty;
  logic [7:0]    in_rdata;
  logic          out_push, out_pop, out_full, out_empty;
  logic [7:0]    out_rdata;
  logic [AW:0]   out_level;
  logic [7:0]    res_q;
  logic [LW-1:0] wcnt;
  logic          gcnt;
  logic [CW-1:0] pix_cnt;
  logic          lat_done;

  assign rx_rise = rx_done & ~rx_done_q;

  esched_fifo #(.DEPTH(DEPTH)) u_in_fifo (
    .clk(clk), .rst(rst), .push(rx_rise), .wdata(rx_data), .pop(in_pop),
    .rdata(in_rdata), .level(in_level), .full(in_full), .empty(in_empty)
  );

  esched_fifo #(.DEPTH(DEPTH)) u_out_fifo (
    .clk(clk), .rst(rst), .push(out_push), .wdata(res_q), .pop(out_pop),
    .rdata(out_rdata), .level(out_level), .full(out_full), .empty(out_empty)
  );

  assign lat_done   = (wcnt == LW'(EDGE_LAT - 1));
  assign edge_en    = (e_state == E_ISSUE);
  assign out_push   = (e_state == E_STORE);
  assign frame_done = out_push && (pix_cnt == CW'(FRAME_PIXELS - 1));
  assign tx_start   = (t_state == T_START);

  // With one pixel in flight, a non-full output FIFO in E_IDLE is the reservation:
  // only the tx side touches it until our own E_STORE push.
  always_comb begin
    e_next = e_state;
    in_pop = 1'b0;
    case (e_state)
      E_IDLE:  if (!in_empty && !out_full) begin
                 in_pop = 1'b1;
                 e_next = E_ISSUE;
               end
      E_ISSUE: e_next = E_WAIT;
      E_WAIT:  if (lat_done) e_next = E_STORE;
      E_STORE: e_next = E_IDLE;
      default: e_next = E_IDLE;
    endcase
  end

  always_comb begin
    t_next  = t_state;
    out_pop = 1'b0;
    case (t_state)
      T_IDLE:  if (!out_empty && !tx_busy) begin
                 out_pop = 1'b1;
                 t_next  = T_START;
               end
      T_START: t_next = T_GUARD;
      T_GUARD: if (gcnt) t_next = T_WAIT;
      T_WAIT:  if (!tx_busy) t_next = T_IDLE;
      default: t_next = T_IDLE;
    endcase
  end

  // rx_done_q resets high so a level already high at release is not a byte.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_done_q   <= 1'b1;
      overflow    <= 1'b0;
      e_state     <= E_IDLE;
      t_state     <= T_IDLE;
      edge_pix_in <= '0;
      res_q       <= '0;
      wcnt        <= '0;
      gcnt        <= 1'b0;
      pix_cnt     <= '0;
      tx_data     <= '0;
    end else begin
      rx_done_q <= rx_done;
      if (rx_rise && in_full) overflow <= 1'b1;
      e_state <= e_next;
      t_state <= t_next;
      if (in_pop) edge_pix_in <= in_rdata;
      if (e_state == E_ISSUE) wcnt <= '0;
      else if (e_state == E_WAIT) wcnt <= wcnt + 1'b1;
      if (e_state == E_WAIT && lat_done) res_q <= edge_pix_out;
      if (out_push) pix_cnt <= frame_done ? '0 : pix_cnt + 1'b1;
      if (t_state == T_START) gcnt <= 1'b0;
      else if (t_state == T_GUARD) gcnt <= 1'b1;
      if (out_pop) tx_data <= out_rdata;
    end
  end
endmodule

// File: doc/edge_stream_sched.md
Name: edge_stream_sched

Overview:
Schedules the pixel stream from the UART receiver, through the Edge filter, and back out of the UART transmitter.
- Detects each received byte and buffers it in an input FIFO.
- Issues one pixel at a time to the Edge filter and captures the result after a fixed latency.
- Queues results in an output FIFO and drains them to the UART transmitter under busy handshake.
- Counts pixels per frame and flags overflow.
Sits in the top level between the uart and Edge instances, replacing ad-hoc transmit glue.

Parameters:
DEPTH, 4, entries per FIFO (power of 2, ≥2)
EDGE_LAT, 1, cycles from edge_en to valid edge_pix_out (≥1)
FRAME_PIXELS, 640, pixels per frame for frame_done

Ports:
clk  in  1  system clock (50 MHz)
rst  in  1  asynchronous reset, active-high
rx_done  in  1  UART receive-complete level; rising edge = new byte
rx_data  in  8  UART received byte, valid when rx_done rises
tx_busy  in  1  UART transmitter busy
tx_start  out  1  one-cycle transmit pulse
tx_data  out  8  byte to transmit; held stable from tx_start until tx_busy falls
edge_en  out  1  one-cycle enable to Edge filter
edge_pix_in  out  8  pixel presented to Edge filter, valid with edge_en
edge_pix_out  in  8  Edge filter result
frame_done  out  1  one-cycle pulse when FRAME_PIXELS results are queued
overflow  out  1  sticky: byte dropped because input FIFO was full
in_level  out  $clog2(DEPTH)+1  input FIFO occupancy (LED debug)

Behaviour:
- Reset, asynchronous and active-high: all outputs 0, both FIFOs empty, FSMs idle, pixel counter 0. The rx_done edge register resets to 1, so a high level at reset release is not counted as a byte.
- Reset mid-operation: the in-flight pixel and any partial transmit are abandoned; nothing is resumed after release.
- RX capture:
  - rx_rise = rx_done & ~rx_done_q.
  - On rx_rise, rx_data is pushed into the input FIFO if it is not full.
  - If the input FIFO is full, the byte is dropped and overflow is set. overflow is cleared only by rst.
  - A push and a pop in the same cycle are both honoured; occupancy is unchanged.
- Edge FSM, one pixel in flight:
  - E_IDLE: if the input FIFO is non-empty and the output FIFO has a free slot not already reserved, pop the input FIFO → E_ISSUE.
  - E_ISSUE: edge_en=1 for exactly one cycle with edge_pix_in = popped byte; reset wait counter → E_WAIT.
  - E_WAIT: count EDGE_LAT cycles after the edge_en cycle, then sample edge_pix_out → E_STORE.
  - E_STORE: push the result into the output FIFO, which cannot be full because the slot was reserved at pop; advance the pixel counter → E_IDLE.
  - Minimum issue spacing: EDGE_LAT+3 cycles.
  - edge_pix_in holds its last value outside E_ISSUE.
- Frame counter:
  - Increments on each E_STORE push.
  - When the counter equals FRAME_PIXELS-1 at a push, frame_done pulses in that same cycle and the counter wraps to 0.
- TX FSM:
  - T_IDLE: if the output FIFO is non-empty and tx_busy=0, pop it into the tx_data register → T_START.
  - T_START: tx_start=1 for one cycle → T_GUARD.
  - T_GUARD: ignore tx_busy for 2 cycles, covering the UART busy assertion delay → T_WAIT.
  - T_WAIT: when tx_busy=0 → T_IDLE.
  - tx_data holds from the pop until the next pop.
  - Back-to-back bytes are separated by at least 4 cycles plus the busy time.
- Ordering: bytes are emitted strictly in receive order; no reordering and no duplication.
- The Edge and TX FSMs run concurrently. The same-cycle output-FIFO push (E_STORE) and pop (T_IDLE) are both honoured.
- Width rules:
  - FIFO pointers are $clog2(DEPTH) bits and wrap naturally.
  - Occupancy is one bit wider.
  - The pixel counter is $clog2(FRAME_PIXELS) bits.

Test Plan:
- Single byte: reset, rx_data=8'h5A with rx_done rising; Edge model returns ~input after EDGE_LAT=1 → edge_en pulses once with 8'h5A, tx_start pulses once with tx_data=8'hA5, and overflow stays 0.
- Burst overflow: hold tx_busy=1 and deliver 10 bytes 8'h01..8'h0A, one per 4 cycles → 4 results fill the output FIFO, 4 bytes sit in the input FIFO, later bytes are dropped, and overflow=1. After tx_busy is released, exactly 8 bytes 8'hFE..8'hF7 are emitted in order.
- Handshake: tx_busy rises 1 cycle after tx_start and stays high 20 cycles → the next tx_start occurs no earlier than 1 cycle after tx_busy falls, and tx_data is stable throughout.
- Frame: FRAME_PIXELS=8, stream 17 bytes → frame_done pulses exactly twice, coinciding with the 8th and 16th output-FIFO pushes.
- Reset mid-flight: assert rst during E_WAIT with 2 bytes queued → all outputs 0 immediately, and no edge_en or tx_start after release until a new rx_rise occurs.
- Reset with rx_done high: release rst while rx_done=1 → no byte is captured; the first capture happens only on the next 0→1 transition.
